shft_deser: RTL and testbench
=============================

Name: shft_deser

Overview:
- Serial-to-parallel receiver. It collects a stream of single bits into WIDTH-bit words and hands each finished word to a downstream consumer over a valid/ready handshake.
- The shift direction is selectable per frame: MSB-first (shift left) or LSB-first (shift right).
- It sits at the receive end of the team's serial shift links, opposite the parallel shifters and serializers.
- Contains a bit counter, a two-state receive FSM, a one-word output buffer and sticky error flags.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), width of the bit counter and of bit_cnt; derived, never overridden.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset. reset==0 at a rising clk edge resets the block.
- shft  input  1  direction, sampled only on frame start. 1 = MSB-first (shift left), 0 = LSB-first (shift right).
- frame_start  input  1  qualifies the current bit_in as the first bit of a new frame; ignored unless bit_valid=1.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data bit.
- data_o  output  WIDTH  assembled word.
- data_valid  output  1  data_o holds an unconsumed word.
- data_ready  input  1  consumer accepts data_o when data_valid & data_ready.
- busy  output  1  a frame is in progress (state RECV).
- bit_cnt  output  CW  bits accepted in the current frame.
- overrun  output  1  sticky: a finished word was dropped because the output buffer was full.
- abort  output  1  sticky: a frame_start arrived while a partial word was in progress.

Behaviour:
- Reset (reset==0 at a clk edge): all outputs, the shift register and internal state return to their reset values.
  - State = IDLE; bit_cnt=0; shift register = 0; data_o=0.
  - data_valid=0, overrun=0, abort=0, busy=0.
  - Reset mid-frame discards the partial word and any buffered word.
- Accepted bit: bit_valid=1 and either of the following holds:
  - state=RECV, or
  - state=IDLE and frame_start=1.
- bit_valid=1 in IDLE without frame_start is ignored.
- FSM states: IDLE, RECV.
  - IDLE -> RECV on frame_start & bit_valid. At that edge: the direction register latches shft; the first bit is shifted in; bit_cnt=1.
  - RECV: each accepted bit shifts in and increments bit_cnt.
  - RECV -> IDLE on the edge that accepts the WIDTH-th bit; bit_cnt returns to 0.
- Shifting, with sreg as the internal shift register:
  - Direction 1: sreg <= {sreg[WIDTH-2:0], bit_in}. The first bit ends up in data_o[WIDTH-1].
  - Direction 0: sreg <= {bit_in, sreg[WIDTH-1:1]}. The first bit ends up in data_o[0].
  - A change of shft mid-frame has no effect on the current frame.
- frame_start & bit_valid while in RECV with bit_cnt>0:
  - The partial word is discarded and abort is set.
  - The current bit restarts the frame: bit_cnt=1, new direction latched, state stays RECV.
- Word completion, on the edge accepting the WIDTH-th bit:
  - The completed word is the sreg value including this bit.
  - If data_valid=0, or data_valid & data_ready in the same cycle: data_o <= word and data_valid=1 from the next cycle. Latency is 1 cycle from the last bit to data_valid.
  - Otherwise the word is dropped, data_o is unchanged and overrun is set.
- Output handshake:
  - data_valid & data_ready with no completion that cycle: data_valid goes to 0 next cycle; data_o holds its value.
  - data_o and data_valid stay stable while data_valid=1 and data_ready=0.
- Sticky flags: overrun and abort clear only on reset.
- Back-to-back frames are legal. A frame_start can arrive on the cycle right after a completion, because state is then IDLE.
- With bit_valid held high, throughput is one word per WIDTH cycles.

Test Plan:
- Reset then MSB-first: shft=1, frame_start on the first bit, bits 1,0,1,1 on consecutive cycles, data_ready=1.
  - Required: data_o=4'b1011, data_valid=1 exactly one cycle after the 4th bit; busy=1 during the frame; bit_cnt steps 1,2,3 then returns to 0.
- LSB-first: shft=0, same bits 1,0,1,1.
  - Required: data_o=4'b1101.
  - Toggling shft to 1 after the first bit still gives 4'b1101.
- Backpressure: data_ready=0, send word 4'hA (MSB-first), then word 4'h5.
  - Required: data_o holds 4'hA with data_valid=1; 4'h5 is dropped; overrun=1.
  - Then data_ready=1: data_valid drops to 0 the next cycle.
- Simultaneous completion and consume: data_valid=1 with data_ready=1 on the same edge that the 4th bit of 4'h3 arrives.
  - Required: data_o=4'h3, data_valid stays 1, overrun stays 0.
- Abort: bits 1,1 then frame_start with bits 0,0,0,1 (MSB-first).
  - Required: abort=1; data_o=4'b0001; bit_cnt resets to 1 on the restart bit.
- Reset mid-operation: drive reset=0 after 2 bits while a word is buffered.
  - Required next cycle: data_valid=0, busy=0, bit_cnt=0, data_o=0, overrun=0, abort=0.
  - Then a fresh frame 4'b0110 is received correctly.

Source files
------------

// File: rtl/shft_deser.sv
// shft_deser: serial-to-parallel receiver.
// Collects single bits into WIDTH-bit words, MSB-first or LSB-first as chosen
// at frame start, and hands each finished word over a valid/ready handshake.
// The output buffer holds one word.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   shft         direction, sampled on frame start (1 = MSB-first, 0 = LSB-first)
//   frame_start  marks bit_in as the first bit of a frame (needs bit_valid)
//   bit_valid    bit_in is valid this cycle
//   bit_in       serial data bit
//   data_o       assembled word
//   data_valid   data_o holds an unconsumed word
//   data_ready   consumer takes data_o when data_valid & data_ready
//   busy         a frame is in progress
//   bit_cnt      bits accepted in the current frame
//   overrun      sticky: a finished word was dropped (buffer full)
//   abort        sticky: a frame restarted over a partial word
module shft_deser #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shft,
  input  logic             frame_start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_o,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
  output logic             abort
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              dir_q, dir_d;
  logic              data_valid_q, data_valid_d;
  logic              overrun_q, overrun_d;
  logic              abort_q, abort_d;

  logic              start, accept, complete, dir_cur;
  logic [WIDTH-1:0]  base, shifted;
  logic [CW-1:0]     cnt_inc;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sreg_d       = sreg_q;
    data_d       = data_q;
    dir_d        = dir_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    abort_d      = abort_q;

    start   = bit_valid & frame_start;
    accept  = bit_valid & ((state_q == RECV) | frame_start);
    // A (re)start takes the fresh direction and begins from an empty register,
    // so a discarded partial word cannot leak into the new frame.
    dir_cur = start ? shft : dir_q;
    base    = start ? '0 : sreg_q;
    shifted = dir_cur ? {base[WIDTH-2:0], bit_in} : {bit_in, base[WIDTH-1:1]};
    cnt_inc = start ? CW'(1) : bit_cnt_q + 1'b1;
    complete = accept && (cnt_inc == CW'(WIDTH));

    if (accept) begin
      dir_d  = dir_cur;
      sreg_d = shifted;
      if (complete) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end else begin
        state_d   = RECV;
        bit_cnt_d = cnt_inc;
      end
    end

    if (start && (state_q == RECV) && (bit_cnt_q != '0))
      abort_d = 1'b1;

    if (data_valid_q && data_ready)
      data_valid_d = 1'b0;

    // Completion may reuse a slot being consumed on the same edge.
    if (complete) begin
      if (!data_valid_q || data_ready) begin
        data_d       = shifted;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      sreg_q       <= '0;
      data_q       <= '0;
      dir_q        <= 1'b0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sreg_q       <= sreg_d;
      data_q       <= data_d;
      dir_q        <= dir_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      abort_q      <= abort_d;
    end
  end

  assign data_o     = data_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q == RECV);
  assign bit_cnt    = bit_cnt_q;
  assign overrun    = overrun_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_shft_deser.sv
// Bench for shft_deser (WIDTH=4). Expected words are queued as frames are
// driven and popped when the DUT presents them.
module tb_shft_deser;
  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             shft, frame_start, bit_valid, bit_in, data_ready;
  logic [WIDTH-1:0] data_o;
  logic             data_valid, busy, overrun, abort;
  logic [CW-1:0]    bit_cnt;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_w;

  shft_deser #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .shft(shft), .frame_start(frame_start),
    .bit_valid(bit_valid), .bit_in(bit_in), .data_o(data_o),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
    .bit_cnt(bit_cnt), .overrun(overrun), .abort(abort)
  );

  always #5 clk = ~clk;

  // One bit across one clock edge; outputs are sampled 1 time unit later.
  task automatic send_bit(input logic fs, input logic sh, input logic b);
    frame_start = fs; shft = sh; bit_in = b; bit_valid = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic idle();
    bit_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop_exp(output logic [WIDTH-1:0] w);
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty: nothing expected");
      w = 'x;
    end else w = exp_q.pop_front();
  endtask

  // Full frame; bit order follows dir so data_o should equal w. With tog the
  // shft input flips after the first bit, which must not matter.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic dir, input logic tog);
    for (int k = 0; k < WIDTH; k++) begin
      send_bit(k == 0, (k > 0 && tog) ? ~dir : dir, dir ? w[WIDTH-1-k] : w[k]);
      if (k < WIDTH - 1) begin
        checks++; if (bit_cnt !== CW'(k + 1)) begin errors++; $display("FAIL bit_cnt: got %0d want %0d", bit_cnt, k + 1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_frame: got %b want 1", busy); end
      end else begin
        checks++; if (bit_cnt !== '0) begin errors++; $display("FAIL bit_cnt_end: got %0d want 0", bit_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end: got %b want 0", busy); end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({data_valid, busy, overrun, abort} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {data_valid, busy, overrun, abort}); end
    checks++; if (bit_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bit_cnt); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    reset = 1'b1;
  endtask

  task automatic test_msb_first();
    data_ready = 1'b1;
    exp_q.push_back(4'b1011);
    // first three bits manually so data_valid can be shown low before the last
    send_bit(1'b1, 1'b1, 1'b1);
    checks++; if (bit_cnt !== CW'(1) || busy !== 1'b1) begin errors++; $display("FAIL msb_cnt1: got %0d/%b want 1/1", bit_cnt, busy); end
    send_bit(1'b0, 1'b1, 1'b0);
    checks++; if (bit_cnt !== CW'(2)) begin errors++; $display("FAIL msb_cnt2: got %0d want 2", bit_cnt); end
    send_bit(1'b0, 1'b1, 1'b1);
    checks++; if (bit_cnt !== CW'(3) || data_valid !== 1'b0) begin errors++; $display("FAIL msb_cnt3: got %0d/%b want 3/0", bit_cnt, data_valid); end
    send_bit(1'b0, 1'b1, 1'b1);
    pop_exp(exp_w);
    checks++; if (data_valid !== 1'b1 || data_o !== exp_w) begin errors++; $display("FAIL msb_word: got %b/%b want 1/%b", data_valid, data_o, exp_w); end
    checks++; if (bit_cnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL msb_end: got %0d/%b want 0/0", bit_cnt, busy); end
    idle();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL msb_consume: got %b want 0", data_valid); end
  endtask

  task automatic test_lsb_first();
    data_ready = 1'b1;
    exp_q.push_back(4'b1101);
    send_word(4'b1101, 1'b0, 1'b0);
    pop_exp(exp_w);
    checks++; if (data_valid !== 1'b1 || data_o !== exp_w) begin errors++; $display("FAIL lsb_word: got %b/%b want 1/%b", data_valid, data_o, exp_w); end
    exp_q.push_back(4'b1101);
    send_word(4'b1101, 1'b0, 1'b1);
    pop_exp(exp_w);
    checks++; if (data_valid !== 1'b1 || data_o !== exp_w) begin errors++; $display("FAIL lsb_toggle: got %b/%b want 1/%b", data_valid, data_o, exp_w); end
    idle();
  endtask

  task automatic test_backpressure();
    data_ready = 1'b0;
    exp_q.push_back(4'hA);
    send_word(4'hA, 1'b1, 1'b0);
    idle();
    checks++; if (data_valid !== 1'b1 || data_o !== exp_q[0]) begin errors++; $display("FAIL bp_hold: got %b/%h want 1/%h", data_valid, data_o, exp_q[0]); end
    send_word(4'h5, 1'b1, 1'b0); // dropped: buffer full
    idle();
    pop_exp(exp_w);
    checks++; if (data_valid !== 1'b1 || data_o !== exp_w) begin errors++; $display("FAIL bp_keep: got %b/%h want 1/%h", data_valid, data_o, exp_w); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b want 1", overrun); end
    data_ready = 1'b1;
    idle();
    checks++; if (data_valid !== 1'b0 || data_o !== exp_w) begin errors++; $display("FAIL bp_release: got %b/%h want 0/%h", data_valid, data_o, exp_w); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    data_ready = 1'b0;
    exp_q.push_back(4'h9);
    send_word(4'h9, 1'b1, 1'b0);
    pop_exp(exp_w);
    checks++; if (data_valid !== 1'b1 || data_o !== exp_w) begin errors++; $display("FAIL b2b_first: got %b/%h want 1/%h", data_valid, data_o, exp_w); end
    // next frame starts right after the completion; consume lands on its last bit
    exp_q.push_back(4'h3);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b1);
    data_ready = 1'b1;
    send_bit(1'b0, 1'b1, 1'b1);
    pop_exp(exp_w);
    checks++; if (data_valid !== 1'b1 || data_o !== exp_w) begin errors++; $display("FAIL b2b_simul: got %b/%h want 1/%h", data_valid, data_o, exp_w); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    idle();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", data_valid); end
  endtask

  task automatic test_abort();
    data_ready = 1'b1;
    send_bit(1'b1, 1'b1, 1'b1);
    send_bit(1'b0, 1'b1, 1'b1);
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL abort_early: got %b want 0", abort); end
    exp_q.push_back(4'b0001);
    send_bit(1'b1, 1'b1, 1'b0);
    checks++; if (abort !== 1'b1 || bit_cnt !== CW'(1) || busy !== 1'b1) begin errors++; $display("FAIL abort_restart: got %b/%0d/%b want 1/1/1", abort, bit_cnt, busy); end
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL abort_early_dv: got %b want 0", data_valid); end
    send_bit(1'b0, 1'b1, 1'b1);
    pop_exp(exp_w);
    checks++; if (data_valid !== 1'b1 || data_o !== exp_w) begin errors++; $display("FAIL abort_word: got %b/%b want 1/%b", data_valid, data_o, exp_w); end
    idle();
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b0;
    send_word(4'hC, 1'b1, 1'b0);   // left buffered, then discarded by reset
    send_word(4'h7, 1'b1, 1'b0);   // dropped: raises overrun
    send_bit(1'b1, 1'b1, 1'b1);
    send_bit(1'b0, 1'b1, 1'b0);
    checks++; if (busy !== 1'b1 || data_valid !== 1'b1 || overrun !== 1'b1 || abort !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b%b%b%b want 1111", busy, data_valid, overrun, abort); end
    do_reset();
    checks++; if ({data_valid, busy, overrun, abort} !== 4'b0) begin errors++; $display("FAIL mid_flags: got %b want 0000", {data_valid, busy, overrun, abort}); end
    checks++; if (bit_cnt !== '0 || data_o !== '0) begin errors++; $display("FAIL mid_state: got %0d/%h want 0/0", bit_cnt, data_o); end
    data_ready = 1'b1;
    exp_q.push_back(4'b0110);
    send_word(4'b0110, 1'b1, 1'b0);
    pop_exp(exp_w);
    checks++; if (data_valid !== 1'b1 || data_o !== exp_w) begin errors++; $display("FAIL mid_fresh: got %b/%b want 1/%b", data_valid, data_o, exp_w); end
    idle();
  endtask

  initial begin
    reset = 1'b0; shft = 1'b0; frame_start = 1'b0; bit_valid = 1'b0;
    bit_in = 1'b0; data_ready = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
